// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter.
// States, port ids and the line-width helper.
package mem_arb_pkg;

    localparam int NrPorts = 2;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I_RD,
        GNT_D_RD,
        GNT_D_WR,
        DONE
    } arb_state_t;

    typedef enum logic [0:0] {
        PORT_I,
        PORT_D
    } port_id_t;

    function automatic int line_size(input int byte_offset_bits);
        return 32 * (2 ** byte_offset_bits) / 4;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick.
// On a tie the port that was not granted last wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [NrPorts-1:0] req,
    input  port_id_t           last_grant,
    output logic               gnt_valid,
    output port_id_t           gnt
);

    // Pick a winner from the request vector
    always_comb begin
        gnt_valid = |req;
        gnt       = PORT_I;
        unique case (1'b1)
            (req[0] && req[1]):
                gnt = (last_grant == PORT_I) ? PORT_D : PORT_I;
            (req[1] && !req[0]):
                gnt = PORT_D;
            default:
                gnt = PORT_I;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the DRAM line port between I-cache and D-cache.
// Optional counters: define MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ByteOffsetBits = 4,
    localparam int LineSize = line_size(ByteOffsetBits)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         i_mem_addr_i,
    input  logic                i_mem_read_en_i,
    output logic                i_mem_read_valid_o,
    output logic [LineSize-1:0] i_mem_read_data_o,
    input  logic [31:0]         d_mem_addr_i,
    input  logic                d_mem_read_en_i,
    output logic                d_mem_read_valid_o,
    output logic [LineSize-1:0] d_mem_read_data_o,
    input  logic                d_mem_write_en_i,
    input  logic [LineSize-1:0] d_mem_write_data_i,
    output logic                d_mem_write_valid_o,
    output logic [31:0]         mem_addr_o,
    output logic                mem_read_en_o,
    input  logic                mem_read_valid_i,
    input  logic [LineSize-1:0] mem_read_data_i,
    output logic                mem_write_en_o,
    output logic [LineSize-1:0] mem_write_data_o,
    input  logic                mem_write_valid_i
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         i_grant_cnt_o,
    output logic [31:0]         d_grant_cnt_o,
    output logic [31:0]         conflict_cnt_o
`endif
);

    arb_state_t          state_q;
    arb_state_t          state_d;
    port_id_t            last_grant_q;
    port_id_t            pick;
    logic                pick_valid;
    logic [NrPorts-1:0]  req;
    logic                grant;
    logic [31:0]         addr_q;
    logic [LineSize-1:0] wdata_q;

    assign req = {d_mem_read_en_i | d_mem_write_en_i,
                  i_mem_read_en_i};

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_valid  (pick_valid),
        .gnt        (pick)
    );

    assign grant = (state_q == IDLE) && pick_valid;

    assign mem_addr_o       = addr_q;
    assign mem_write_data_o = wdata_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a grant lasts until the matching memory valid
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (pick == PORT_I) begin
                        state_d = GNT_I_RD;
                    end else if (d_mem_write_en_i) begin
                        state_d = GNT_D_WR;
                    end else begin
                        state_d = GNT_D_RD;
                    end
                end
            end
            GNT_I_RD, GNT_D_RD: begin
                if (mem_read_valid_i) begin
                    state_d = DONE;
                end
            end
            GNT_D_WR: begin
                if (mem_write_valid_i) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch winner, address and write line on grant entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= PORT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant) begin
            last_grant_q <= pick;
            if (pick == PORT_I) begin
                addr_q <= i_mem_addr_i;
            end else begin
                addr_q <= d_mem_addr_i;
                if (d_mem_write_en_i) begin
                    wdata_q <= d_mem_write_data_i;
                end
            end
        end
    end

    // Enables and completion routing to the granted port only
    always_comb begin
        mem_read_en_o       = 1'b0;
        mem_write_en_o      = 1'b0;
        i_mem_read_valid_o  = 1'b0;
        d_mem_read_valid_o  = 1'b0;
        d_mem_write_valid_o = 1'b0;
        i_mem_read_data_o   = '0;
        d_mem_read_data_o   = '0;
        unique case (state_q)
            GNT_I_RD: begin
                mem_read_en_o      = 1'b1;
                i_mem_read_valid_o = mem_read_valid_i;
                i_mem_read_data_o  = mem_read_data_i;
            end
            GNT_D_RD: begin
                mem_read_en_o      = 1'b1;
                d_mem_read_valid_o = mem_read_valid_i;
                d_mem_read_data_o  = mem_read_data_i;
            end
            GNT_D_WR: begin
                mem_write_en_o      = 1'b1;
                d_mem_write_valid_o = mem_write_valid_i;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // Grant and conflict counters, free-running wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_grant_cnt_o  <= '0;
            d_grant_cnt_o  <= '0;
            conflict_cnt_o <= '0;
        end else if (state_q == IDLE) begin
            if (grant && pick == PORT_I) begin
                i_grant_cnt_o <= i_grant_cnt_o + 32'd1;
            end
            if (grant && pick == PORT_D) begin
                d_grant_cnt_o <= d_grant_cnt_o + 32'd1;
            end
            if (&req) begin
                conflict_cnt_o <= conflict_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a DRAM model
// and a queue-based round-robin reference.
module tb_mem_port_arbiter;

    localparam int LS = 128;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   i_mem_addr_i;
    logic          i_mem_read_en_i;
    logic          i_mem_read_valid_o;
    logic [LS-1:0] i_mem_read_data_o;
    logic [31:0]   d_mem_addr_i;
    logic          d_mem_read_en_i;
    logic          d_mem_read_valid_o;
    logic [LS-1:0] d_mem_read_data_o;
    logic          d_mem_write_en_i;
    logic [LS-1:0] d_mem_write_data_i;
    logic          d_mem_write_valid_o;
    logic [31:0]   mem_addr_o;
    logic          mem_read_en_o;
    logic          mem_read_valid_i;
    logic [LS-1:0] mem_read_data_i;
    logic          mem_write_en_o;
    logic [LS-1:0] mem_write_data_o;
    logic          mem_write_valid_i;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   i_grant_cnt_o;
    logic [31:0]   d_grant_cnt_o;
    logic [31:0]   conflict_cnt_o;
`endif

    mem_port_arbiter dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .i_mem_addr_i        (i_mem_addr_i),
        .i_mem_read_en_i     (i_mem_read_en_i),
        .i_mem_read_valid_o  (i_mem_read_valid_o),
        .i_mem_read_data_o   (i_mem_read_data_o),
        .d_mem_addr_i        (d_mem_addr_i),
        .d_mem_read_en_i     (d_mem_read_en_i),
        .d_mem_read_valid_o  (d_mem_read_valid_o),
        .d_mem_read_data_o   (d_mem_read_data_o),
        .d_mem_write_en_i    (d_mem_write_en_i),
        .d_mem_write_data_i  (d_mem_write_data_i),
        .d_mem_write_valid_o (d_mem_write_valid_o),
        .mem_addr_o          (mem_addr_o),
        .mem_read_en_o       (mem_read_en_o),
        .mem_read_valid_i    (mem_read_valid_i),
        .mem_read_data_i     (mem_read_data_i),
        .mem_write_en_o      (mem_write_en_o),
        .mem_write_data_o    (mem_write_data_o),
        .mem_write_valid_i   (mem_write_valid_i)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .i_grant_cnt_o       (i_grant_cnt_o),
        .d_grant_cnt_o       (d_grant_cnt_o),
        .conflict_cnt_o      (conflict_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            port;
        bit            wr;
        logic [31:0]   addr;
        logic [LS-1:0] wdata;
    } txn_t;

    txn_t          expq[$];
    logic [LS-1:0] mem [logic [31:0]];
    int            vectors = 0;
    int            miscompares = 0;
    int            model_last = 1;
    int            m_i_gr = 0;
    int            m_d_gr = 0;
    int            m_conf = 0;

    task automatic chk(input string tag,
                       input logic [LS-1:0] got,
                       input logic [LS-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LS-1:0] line_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'h1};
    endfunction

    task automatic run_round(input bit ir, input bit dr, input bit dw,
                             input logic [31:0] ia,
                             input logic [31:0] da,
                             input logic [LS-1:0] wd,
                             input int lat);
        txn_t iq[$];
        txn_t dq[$];
        txn_t cur;
        bit   active;
        bit   first;
        bit   fire;
        int   cnt;
        int   gap;
        int   guard;
        int   who;
        if (ir) iq.push_back('{0, 1'b0, ia, '0});
        if (dw) dq.push_back('{1, 1'b1, da, wd});
        if (dr) dq.push_back('{1, 1'b0, da, '0});
        while (iq.size() != 0 || dq.size() != 0) begin
            if (iq.size() != 0 && dq.size() != 0) begin
                who = (model_last == 0) ? 1 : 0;
                m_conf++;
            end else begin
                who = (iq.size() != 0) ? 0 : 1;
            end
            model_last = who;
            if (who == 0) begin
                expq.push_back(iq.pop_front());
                m_i_gr++;
            end else begin
                expq.push_back(dq.pop_front());
                m_d_gr++;
            end
        end
        i_mem_addr_i       = ia;
        i_mem_read_en_i    = ir;
        d_mem_addr_i       = da;
        d_mem_read_en_i    = dr;
        d_mem_write_en_i   = dw;
        d_mem_write_data_i = wd;
        active = 1'b0;
        first  = 1'b1;
        cnt    = 0;
        gap    = 0;
        guard  = 0;
        while ((expq.size() != 0 || active) && guard < 400) begin
            @(posedge clk_i);
            #2;
            guard++;
            mem_read_valid_i  = 1'b0;
            mem_write_valid_i = 1'b0;
            fire = 1'b0;
            if (!active) begin
                if (mem_read_en_o || mem_write_en_o) begin
                    cur = expq.pop_front();
                    chk("issue_op", LS'({mem_read_en_o, mem_write_en_o}),
                        cur.wr ? LS'(2'b01) : LS'(2'b10));
                    chk("issue_addr", LS'(mem_addr_o), LS'(cur.addr));
                    if (cur.wr) chk("issue_wdata", mem_write_data_o, cur.wdata);
                    if (!first) chk("en_low_gap", LS'(gap), LS'(2));
                    active = 1'b1;
                    cnt    = 0;
                end else begin
                    gap++;
                end
            end
            if (active) begin
                if (cnt > 0) begin
                    chk("en_held", LS'({mem_read_en_o, mem_write_en_o}),
                        cur.wr ? LS'(2'b01) : LS'(2'b10));
                end
                cnt++;
                mem_read_data_i = {$urandom, $urandom, $urandom, $urandom};
                if (cnt == lat) begin
                    fire = 1'b1;
                    if (cur.wr) begin
                        mem_write_valid_i = 1'b1;
                    end else begin
                        mem_read_valid_i = 1'b1;
                        mem_read_data_i  = line_at(cur.addr);
                    end
                end
            end
            #1;
            chk("i_rd_valid", LS'(i_mem_read_valid_o),
                LS'(fire && cur.port == 0));
            chk("d_rd_valid", LS'(d_mem_read_valid_o),
                LS'(fire && cur.port == 1 && !cur.wr));
            chk("d_wr_valid", LS'(d_mem_write_valid_o),
                LS'(fire && cur.wr));
            if (fire) begin
                if (cur.wr) begin
                    chk("i_data_zero", i_mem_read_data_o, '0);
                    chk("d_data_zero", d_mem_read_data_o, '0);
                    mem[cur.addr] = cur.wdata;
                    d_mem_write_en_i = 1'b0;
                end else if (cur.port == 0) begin
                    chk("i_rd_data", i_mem_read_data_o, line_at(cur.addr));
                    chk("d_data_zero", d_mem_read_data_o, '0);
                    i_mem_read_en_i = 1'b0;
                end else begin
                    chk("d_rd_data", d_mem_read_data_o, line_at(cur.addr));
                    chk("i_data_zero", i_mem_read_data_o, '0);
                    d_mem_read_en_i = 1'b0;
                end
                active = 1'b0;
                first  = 1'b0;
                gap    = 0;
            end
        end
        if (guard >= 400) begin
            chk("round_timeout", LS'(1), LS'(0));
            expq.delete();
            i_mem_read_en_i  = 1'b0;
            d_mem_read_en_i  = 1'b0;
            d_mem_write_en_i = 1'b0;
        end
        @(posedge clk_i);
        #2;
        mem_read_valid_i  = 1'b0;
        mem_write_valid_i = 1'b0;
        chk("done_en_low", LS'({mem_read_en_o, mem_write_en_o}), LS'(0));
        @(posedge clk_i);
        #2;
        chk("idle_en_low", LS'({mem_read_en_o, mem_write_en_o}), LS'(0));
        chk("idle_i_data", i_mem_read_data_o, '0);
    endtask

    task automatic reset_midwrite();
        d_mem_addr_i       = 32'h0000_0040;
        d_mem_write_data_i = {4{32'h1234_5678}};
        d_mem_write_en_i   = 1'b1;
        repeat (5) begin
            @(posedge clk_i);
            #2;
        end
        chk("pre_rst_wr_en", LS'(mem_write_en_o), LS'(1));
        rst_i = 1'b1;
        #1;
        chk("rst_wr_en", LS'(mem_write_en_o), LS'(0));
        chk("rst_rd_en", LS'(mem_read_en_o), LS'(0));
        chk("rst_wr_valid", LS'(d_mem_write_valid_o), LS'(0));
        chk("rst_addr", LS'(mem_addr_o), LS'(0));
        @(posedge clk_i);
        #2;
        rst_i             = 1'b0;
        d_mem_write_en_i  = 1'b0;
        mem_write_valid_i = 1'b1;
        model_last = 1;
        m_i_gr = 0;
        m_d_gr = 0;
        m_conf = 0;
        #1;
        chk("late_valid_drop", LS'(d_mem_write_valid_o), LS'(0));
        @(posedge clk_i);
        #2;
        mem_write_valid_i = 1'b0;
        chk("late_valid_idle", LS'({mem_read_en_o, mem_write_en_o}), LS'(0));
    endtask

    initial begin
        rst_i              = 1'b1;
        i_mem_addr_i       = '0;
        i_mem_read_en_i    = 1'b0;
        d_mem_addr_i       = '0;
        d_mem_read_en_i    = 1'b0;
        d_mem_write_en_i   = 1'b0;
        d_mem_write_data_i = '0;
        mem_read_valid_i   = 1'b0;
        mem_read_data_i    = '0;
        mem_write_valid_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_en", LS'({mem_read_en_o, mem_write_en_o}), LS'(0));
        chk("rst_valids", LS'({i_mem_read_valid_o, d_mem_read_valid_o,
                               d_mem_write_valid_o}), LS'(0));
        chk("rst_addr", LS'(mem_addr_o), LS'(0));
        chk("rst_wdata", mem_write_data_o, '0);
        chk("rst_i_data", i_mem_read_data_o, '0);
        chk("rst_d_data", d_mem_read_data_o, '0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #2;
        run_round(1, 1, 0, 32'h114, 32'h214, '0, 4);
        run_round(1, 0, 0, 32'h10, 32'h0, '0, 10);
        run_round(0, 0, 1, 32'h0, 32'h18, {4{32'hABCD_ABCD}}, 3);
        run_round(1, 0, 0, 32'h18, 32'h0, '0, 2);
        chk("abcd_line", line_at(32'h18), {4{32'hABCD_ABCD}});
        for (int k = 0; k < 3; k++) begin
            run_round(1, 1, 0, 32'h100 + 32'(k * 16),
                      32'h200 + 32'(k * 16), '0, 1 + k);
        end
        run_round(0, 1, 1, 32'h0, 32'h31c,
                  {$urandom, $urandom, $urandom, $urandom}, 2);
        reset_midwrite();
        run_round(1, 0, 0, 32'h18, 32'h0, '0, 3);
        for (int n = 0; n < 60; n++) begin
            bit ir;
            bit dr;
            bit dw;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            run_round(ir, dr, dw,
                      32'($urandom_range(0, 7) * 16),
                      32'($urandom_range(0, 7) * 16),
                      {$urandom, $urandom, $urandom, $urandom},
                      $urandom_range(1, 8));
        end
`ifdef MEM_ARB_PERF_CNT_EN
        chk("i_grant_cnt", LS'(i_grant_cnt_o), LS'(m_i_gr));
        chk("d_grant_cnt", LS'(d_grant_cnt_o), LS'(m_d_gr));
        chk("conflict_cnt", LS'(conflict_cnt_o), LS'(m_conf));
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
